// File: rtl/hit_resolver.sv
// Two-player hit/block resolver: one stun FSM per victim plus a per-attacker connect latch.
// Optional build macro GUARD_BREAK_EN: a guarding victim with zero block count takes a hit.

module hit_victim #(
    parameter int HITSTUN_CYCLES   = 20,
    parameter int BLOCKSTUN_CYCLES = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       connect,
    input  logic       guard,
    input  logic [2:0] block,
    output logic       hit_pulse,
    output logic       blk_pulse,
    output logic       stunned,
    output logic [1:0] stun_kind
);
    typedef enum logic [1:0] {IDLE = 2'd0, HITSTUN = 2'd1, BLOCKSTUN = 2'd2} state_t;

    localparam logic [4:0] HIT_LOAD = 5'(HITSTUN_CYCLES - 1);
    localparam logic [4:0] BLK_LOAD = 5'(BLOCKSTUN_CYCLES - 1);

    state_t     state, state_nxt;
    logic [4:0] cnt, cnt_nxt;
    logic       take_hit;
    logic       accept;

`ifdef GUARD_BREAK_EN
    assign take_hit = ~guard | (block == 3'd0);
`else
    logic unused_block;
    assign unused_block = ^block;
    assign take_hit     = ~guard;
`endif

    // Connects landing while already stunned are dropped, including the final stun cycle.
    assign accept = (state == IDLE) & connect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hit_pulse <= 1'b0;
            blk_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            hit_pulse <= accept & take_hit;
            blk_pulse <= accept & ~take_hit;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (connect) begin
                    state_nxt = take_hit ? HITSTUN : BLOCKSTUN;
                    cnt_nxt   = take_hit ? HIT_LOAD : BLK_LOAD;
                end
            end
            HITSTUN, BLOCKSTUN: begin
                if (cnt == 5'd0) state_nxt = IDLE;
                else             cnt_nxt   = cnt - 5'd1;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        stunned   = 1'b0;
        stun_kind = 2'b00;
        case (state)
            HITSTUN: begin
                stunned   = 1'b1;
                stun_kind = 2'b01;
            end
            BLOCKSTUN: begin
                stunned   = 1'b1;
                stun_kind = 2'b10;
            end
            default: ;
        endcase
    end
endmodule

module hit_resolver #(
    parameter int HITSTUN_CYCLES   = 20,
    parameter int BLOCKSTUN_CYCLES = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p1_attack,
    input  logic       p2_attack,
    input  logic       p1_overlap,
    input  logic       p2_overlap,
    input  logic       p1_guard,
    input  logic       p2_guard,
    input  logic [2:0] p1_block,
    input  logic [2:0] p2_block,
    output logic       p1_hit_pulse,
    output logic       p2_hit_pulse,
    output logic       p1_blk_pulse,
    output logic       p2_blk_pulse,
    output logic       p1_stunned,
    output logic       p2_stunned,
    output logic [1:0] p1_stun_kind,
    output logic [1:0] p2_stun_kind
);
    localparam int NUM_PLAYERS = 2;

    // Index 0 is P1, index 1 is P2; attacker arrays are indexed by attacker.
    logic [NUM_PLAYERS-1:0]       attack, overlap, guard, conn, connect;
    logic [NUM_PLAYERS-1:0]       hit_pulse, blk_pulse, stunned;
    logic [NUM_PLAYERS-1:0][2:0]  block;
    logic [NUM_PLAYERS-1:0][1:0]  stun_kind;

    assign attack  = {p2_attack, p1_attack};
    assign overlap = {p2_overlap, p1_overlap};
    assign guard   = {p2_guard, p1_guard};
    assign block   = {p2_block, p1_block};

    // Latch holds from the connect until the attacker drops its attack, so one swing hits once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) conn <= '0;
        else     conn <= attack & (conn | overlap);
    end

    for (genvar v = 0; v < NUM_PLAYERS; v++) begin : g_victim
        localparam int A = NUM_PLAYERS - 1 - v;
        assign connect[v] = attack[A] & overlap[A] & ~conn[A];

        hit_victim #(
            .HITSTUN_CYCLES  (HITSTUN_CYCLES),
            .BLOCKSTUN_CYCLES(BLOCKSTUN_CYCLES)
        ) u_victim (
            .clk      (clk),
            .rst      (rst),
            .connect  (connect[v]),
            .guard    (guard[v]),
            .block    (block[v]),
            .hit_pulse(hit_pulse[v]),
            .blk_pulse(blk_pulse[v]),
            .stunned  (stunned[v]),
            .stun_kind(stun_kind[v])
        );
    end

    assign p1_hit_pulse = hit_pulse[0];
    assign p2_hit_pulse = hit_pulse[1];
    assign p1_blk_pulse = blk_pulse[0];
    assign p2_blk_pulse = blk_pulse[1];
    assign p1_stunned   = stunned[0];
    assign p2_stunned   = stunned[1];
    assign p1_stun_kind = stun_kind[0];
    assign p2_stun_kind = stun_kind[1];
endmodule
